// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU defaults, sequencer states and counter sizing
package alu_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int OUT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The bit counter must be able to hold WIDTH itself, the terminal count.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/serial_fs_cell.sv
// rtl/serial_fs_cell.sv - one-bit full subtractor; adds when SEQ_SUB_ADD_MODE_EN and mode=1
module serial_fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  input  logic mode,
  output logic d,
  output logic bout
);

  logic sub_bout;

  assign d        = x ^ y ^ bin;
  assign sub_bout = (~x & y) | (~(x ^ y) & bin);

`ifdef SEQ_SUB_ADD_MODE_EN
  logic add_cout;

  assign add_cout = (x & y) | (bin & (x ^ y));
  assign bout     = mode ? add_cout : sub_bout;
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign bout        = sub_bout;
`endif

endmodule

// File: rtl/seq_subtractor.sv
// rtl/seq_subtractor.sv - bit-serial a-b with ALU flags and start/busy/done handshake
// Optional add mode (extra mode port) is built when SEQ_SUB_ADD_MODE_EN is defined.
module seq_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_SUB_ADD_MODE_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] out,
  output logic             borrow,
  output logic             zero,
  output logic             parity,
  output logic             sign,
  output logic             overflow
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             mode_q, mode_d;
  logic             mode_in;

  logic [OUT_W-1:0] out_q, out_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;

  logic             cell_d, cell_bout;
  logic [OUT_W-1:0] res_out;
  logic             res_ovf;
  logic             a_msb, b_msb, d_msb;

`ifdef SEQ_SUB_ADD_MODE_EN
  assign mode_in = mode;
`else
  assign mode_in = 1'b0;
`endif

  serial_fs_cell u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (bin_q),
    .mode (mode_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Operands are rotated, not shifted, so after WIDTH steps they are intact
  // again and their MSBs are available for the overflow rule.
  assign a_msb = a_q[WIDTH-1];
  assign b_msb = b_q[WIDTH-1];
  assign d_msb = diff_q[WIDTH-1];

  always_comb begin
    res_out              = '0;
    res_out[WIDTH-1:0]   = diff_q;
    for (int i = WIDTH; i < OUT_W; i++) begin
      res_out[i] = (mode_q && (i != WIDTH)) ? 1'b0 : bin_q;
    end
    if (mode_q) begin
      res_ovf = (a_msb == b_msb) && (d_msb != a_msb);
    end else begin
      res_ovf = (a_msb != b_msb) && (d_msb != a_msb);
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    mode_d   = mode_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode_in;
          diff_d  = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          out_d    = res_out;
          borrow_d = bin_q;
          zero_d   = (diff_q == '0);
          parity_d = ^diff_q;
          sign_d   = d_msb;
          ovf_d    = res_ovf;
          state_d  = DONE;
        end else begin
          diff_d = {cell_d, diff_q[WIDTH-1:1]};
          bin_d  = cell_bout;
          a_d    = {a_q[0], a_q[WIDTH-1:1]};
          b_d    = {b_q[0], b_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      mode_q   <= 1'b0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      mode_q   <= mode_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign out      = out_q;
  assign borrow   = borrow_q;
  assign zero     = zero_q;
  assign parity   = parity_q;
  assign sign     = sign_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_subtractor.sv
// tb/tb_seq_subtractor.sv - directed vectors for seq_subtractor (WIDTH=4, OUT_W=8)
module tb_seq_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b;
  logic       busy, done;
  logic [7:0] out;
  logic       borrow, zero, parity, sign, overflow;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int busy_cnt, done_cnt, done_edge;

  always #5 clk = ~clk;

  seq_subtractor #(.WIDTH(4), .OUT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .borrow   (borrow),
    .zero     (zero),
    .parity   (parity),
    .sign     (sign),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] e_out, input logic e_brw,
                         input logic e_zero, input logic e_par, input logic e_sign,
                         input logic e_ovf);
    chk({tag, ".out"}, 32'(out), 32'(e_out));
    chk({tag, ".borrow"}, 32'(borrow), 32'(e_brw));
    chk({tag, ".zero"}, 32'(zero), 32'(e_zero));
    chk({tag, ".parity"}, 32'(parity), 32'(e_par));
    chk({tag, ".sign"}, 32'(sign), 32'(e_sign));
    chk({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
  endtask

  // Drives start at a negedge; returns just after edge 0 has sampled it.
  task automatic start_op(input logic [3:0] va, input logic [3:0] vb);
    @(negedge clk);
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Observes the negedge following each edge k0..7; checks results when done is seen.
  task automatic watch(input string tag, input int k0, input logic [7:0] e_out,
                       input logic e_brw, input logic e_zero, input logic e_par,
                       input logic e_sign, input logic e_ovf);
    busy_cnt  = 0;
    done_cnt  = 0;
    done_edge = -1;
    for (int k = k0; k < 8; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_edge = k;
        chk_res(tag, e_out, e_brw, e_zero, e_par, e_sign, e_ovf);
      end
    end
    chk({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, ".done_edge"}, 32'(done_edge), 32'd5);
    chk({tag, ".held_out"}, 32'(out), 32'(e_out));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk_res("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(4'd3, 4'd1);
    watch("3-1", 0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("3-1.busy_cycles", 32'(busy_cnt), 32'd6);

    start_op(4'd3, 4'd5);
    watch("3-5", 0, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    start_op(4'b0111, 4'b1000);
    watch("7-8", 0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    start_op(4'd0, 4'd0);
    watch("0-0", 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("0-0.busy_cycles", 32'(busy_cnt), 32'd6);

    // Second start two cycles in, with new operands, must be ignored.
    start_op(4'd9, 4'd2);
    @(negedge clk);
    @(negedge clk);
    a     = 4'd1;
    b     = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    watch("9-2", 2, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("9-2.busy_after_restart", 32'(busy_cnt), 32'd4);

    // Abort mid-operation: outputs clear at once, no done.
    start_op(4'd4, 4'd2);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk_res("abort", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort.no_done", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;

    start_op(4'd6, 4'd6);
    watch("6-6", 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/seq_subtractor.md
Name: seq_subtractor

Overview:
- Multi-cycle, bit-serial WIDTH-bit subtractor. Computes a − b one bit per clock through a single one-bit full-subtractor cell.
- Reports the same flag set as the ALU's combinational adder: borrow, zero, parity, sign, overflow.
- Sits beside full_adder in the ALU datapath as the inverse operation. Uses a start/busy/done handshake so the ALU controller can sequence it.

Parameters:
- WIDTH, 4, operand width in bits (≥2)
- OUT_W, 8, result bus width (> WIDTH)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- a  in  WIDTH  minuend, latched on accepted start
- b  in  WIDTH  subtrahend, latched on accepted start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when results are valid
- out  out  OUT_W  difference: diff[WIDTH-1:0], upper bits all = borrow (two's-complement extension)
- borrow  out  1  unsigned borrow out of MSB (a < b)
- zero  out  1  diff == 0
- parity  out  1  XOR of diff bits
- sign  out  1  diff[WIDTH-1]
- overflow  out  1  signed overflow: a[MSB]≠b[MSB] && diff[MSB]≠a[MSB]

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, bit counter=0, borrow chain=0, shift registers=0. All outputs 0 (busy, done, out, borrow, zero, parity, sign, overflow).
- States:
  - IDLE: start=1 → latch a, b; clear diff register, borrow chain and counter → SHIFT.
  - SHIFT: per cycle, process bit i = counter, LSB first.
    - d = a[i]^b[i]^bin
    - bout = (~a[i]&b[i]) | (~(a[i]^b[i])&bin)
    - Shift d into the diff register; bin ← bout; counter+1.
    - After bit WIDTH-1 → DONE.
  - DONE: register out and all flags from final diff/borrow; done=1 for exactly this cycle → IDLE.
- Latency: start sampled at edge 0 → done high in the cycle after edge WIDTH+1. For WIDTH=4, done is seen at edge 6.
- Throughput: one operation per WIDTH+2 cycles. A new start is accepted in the first IDLE cycle after DONE.
- start while busy (SHIFT or DONE): ignored. Latched operands unchanged.
- Input changes on a/b after acceptance: no effect.
- Result outputs hold their values from the last DONE until the next DONE or reset. They are not cleared on start.
- Reset mid-operation: immediate abort to IDLE, all outputs 0, no done pulse.
- Arithmetic is modular in WIDTH bits. borrow=1 iff a < b unsigned. out upper bits replicate borrow, so 3−5 yields 8'hFE.

Optional Feature:
- SEQ_SUB_ADD_MODE_EN
- Defined:
  - Adds input port mode (1 bit), latched with operands.
  - mode=1: the cell computes a+b (d=a^b^cin, cout=majority). borrow reports carry-out. out upper bits = {0…, carry}, so 15+1 yields 8'h10. overflow uses the add rule: a[MSB]==b[MSB] && diff[MSB]≠a[MSB].
  - mode=0: identical to subtract-only behaviour.
- Undefined: no mode port; subtract only.

Decomposition:
- Package alu_pkg:
  - WIDTH/OUT_W defaults
  - state typedef {IDLE, SHIFT, DONE}
  - counter width constant $clog2(WIDTH+1)
- Sub-module serial_fs_cell: combinational one-bit full subtractor (adder when the macro is enabled and mode=1). Inputs x, y, bin, mode; outputs d, bout. Instantiated once.

Test Plan:
- a=3, b=1, start 1 cycle → done at edge 6; out=8'h02, borrow=0, zero=0, parity=1, sign=0, overflow=0.
- a=3, b=5 → out=8'hFE, borrow=1, zero=0, parity=1, sign=1, overflow=0.
- a=4'b0111, b=4'b1000 → out=8'hFF, borrow=1, sign=1, parity=0, overflow=1.
- a=0, b=0 → out=8'h00, zero=1, parity=0, borrow=0; done for exactly one cycle; busy high for 6 cycles.
- Start a=9, b=2; pulse start again with a=1, b=1 two cycles later → second start ignored; result out=8'h07, flags for 7.
- Start a=4, b=2; drop rst_n at cycle 2 → all outputs 0 immediately, no done. Release reset, start a=6, b=6 → zero=1 at the correct latency.
